// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: shared pipeline packet types, width encodings and access helpers.
package PipelineTypes;

    typedef enum logic {IDLE, WAIT_ACK} MemAccessState;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef struct packed {
        logic [4:0] rdAddr;
        logic       rdWe;
    } RdCtrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic        isLoad;
        logic        isStore;
        logic        isLoadUnsigned;
        logic [1:0]  memWidth;
        RdCtrl       rdCtrl;
    } MemoryAccessStagePipeReg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] r_data;
        logic        is_load;
        RdCtrl       rdCtrl;
    } WriteBackStagePipeReg;

    // Width 2'b11 is handled as a word everywhere.
    function automatic logic isAligned(input logic [1:0] width, input logic [1:0] addr);
        return width == MEM_BYTE || (width == MEM_HALF ? !addr[0] : addr == 2'b00);
    endfunction

    function automatic logic [3:0] byteEnables(input logic [1:0] width, input logic [1:0] addr);
        return width == MEM_BYTE ? 4'b0001 << addr : width == MEM_HALF ? 4'b0011 << addr : 4'b1111;
    endfunction

    function automatic logic [31:0] laneData(input logic [1:0] width, input logic [31:0] data);
        return width == MEM_BYTE ? {4{data[7:0]}} : width == MEM_HALF ? {2{data[15:0]}} : data;
    endfunction

endpackage

// File: rtl/memory_access_stage_load_data_aligner.sv
// load_data_aligner: picks the addressed lane of a read word and sign/zero-extends it.
module load_data_aligner
    import PipelineTypes::*;
(
    input  logic [31:0] rData,
    input  logic [1:0]  addrLow,
    input  logic [1:0]  width,
    input  logic        isUnsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rData >> {addrLow, 3'b000};
    assign data = width == MEM_BYTE ? {{24{!isUnsigned & shifted[7]}}, shifted[7:0]} :
                  width == MEM_HALF ? {{16{!isUnsigned & shifted[15]}}, shifted[15:0]} : rData;

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: issues data-memory accesses for the pipeline and forwards results to write-back.
module memory_access_stage
    import PipelineTypes::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  MemoryAccessStagePipeReg memPipeReg,
    input  logic                    memValid,
    output WriteBackStagePipeReg    wbPipeReg,
    output logic                    wbValid,
    output logic                    memStall,
    output logic                    dmemReq,
    output logic                    dmemWe,
    output logic [31:0]             dmemAddr,
    output logic [31:0]             dmemWData,
    output logic [3:0]              dmemBe,
    input  logic                    dmemAck,
    input  logic [31:0]             dmemRData,
    output logic                    misalignFault,
    output logic                    busTimeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    MemAccessState        state;
    logic [CW-1:0]        waitCount;
    logic                 memOp;
    logic                 aligned;
    logic                 timeoutNow;
    logic [31:0]          loadData;
    WriteBackStagePipeReg result;

    assign memOp      = memValid & (memPipeReg.isLoad | memPipeReg.isStore);
    assign aligned    = isAligned(memPipeReg.memWidth, memPipeReg.aluResult[1:0]);
    assign timeoutNow = state == WAIT_ACK && !dmemAck && waitCount == CW'(ACK_TIMEOUT - 1);
    // Upstream holds the instruction until the access resolves; it is released on ack or timeout.
    assign memStall   = state == IDLE ? memOp & aligned : !dmemAck & !timeoutNow;

    load_data_aligner aligner (
        .rData      (dmemRData),
        .addrLow    (memPipeReg.aluResult[1:0]),
        .width      (memPipeReg.memWidth),
        .isUnsigned (memPipeReg.isLoadUnsigned),
        .data       (loadData)
    );

    assign result = '{
        pc:         memPipeReg.pc,
        alu_result: memPipeReg.aluResult,
        r_data:     memPipeReg.isLoad ? loadData : 32'd0,
        is_load:    memPipeReg.isLoad,
        rdCtrl:     memPipeReg.rdCtrl
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            waitCount     <= '0;
            wbValid       <= 1'b0;
            wbPipeReg     <= '0;
            dmemReq       <= 1'b0;
            dmemWe        <= 1'b0;
            dmemAddr      <= '0;
            dmemWData     <= '0;
            dmemBe        <= '0;
            misalignFault <= 1'b0;
            busTimeout    <= 1'b0;
        end else begin
            wbValid       <= 1'b0;
            misalignFault <= 1'b0;
            busTimeout    <= 1'b0;
            if (state == IDLE) begin
                if (memOp && aligned) begin
                    state     <= WAIT_ACK;
                    waitCount <= '0;
                    dmemReq   <= 1'b1;
                    dmemWe    <= memPipeReg.isStore;
                    dmemAddr  <= {memPipeReg.aluResult[31:2], 2'b00};
                    dmemBe    <= byteEnables(memPipeReg.memWidth, memPipeReg.aluResult[1:0]);
                    dmemWData <= laneData(memPipeReg.memWidth, memPipeReg.storeData);
                end else if (memOp) begin
                    misalignFault <= 1'b1;
                end else if (memValid) begin
                    wbValid   <= 1'b1;
                    wbPipeReg <= result;
                end
            end else if (dmemAck) begin
                state     <= IDLE;
                dmemReq   <= 1'b0;
                wbValid   <= 1'b1;
                wbPipeReg <= result;
            end else if (timeoutNow) begin
                state      <= IDLE;
                dmemReq    <= 1'b0;
                busTimeout <= 1'b1;
            end else begin
                waitCount <= waitCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: randomized scoreboard bench with a behavioural memory-stage model.
module tb_memory_access_stage;
    import PipelineTypes::*;

    localparam int T = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    MemoryAccessStagePipeReg memPipeReg;
    logic                    memValid;
    WriteBackStagePipeReg    wbPipeReg;
    logic                    wbValid, memStall, dmemReq, dmemWe, dmemAck;
    logic [31:0]             dmemAddr, dmemWData, dmemRData;
    logic [3:0]              dmemBe;
    logic                    misalignFault, busTimeout;

    memory_access_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .memPipeReg(memPipeReg), .memValid(memValid),
        .wbPipeReg(wbPipeReg), .wbValid(wbValid), .memStall(memStall),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWData(dmemWData),
        .dmemBe(dmemBe), .dmemAck(dmemAck), .dmemRData(dmemRData),
        .misalignFault(misalignFault), .busTimeout(busTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]           kind;
        WriteBackStagePipeReg wb;
    } Event;

    localparam logic [2:0] EV_WB = 3'b100, EV_MIS = 3'b010, EV_TMO = 3'b001;

    Event        expQ[$];
    Event        got;
    int          errors = 0, checks = 0;
    int          ackDelay = 0, reqCycle = 0;
    logic        reqAllowed = 1'b0, forceAck = 1'b0;
    logic        expWe;
    logic [31:0] expAddr, expWData, rdWord;
    logic [3:0]  expBe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ackDelay wait cycles, stray acks whenever idle.
    initial begin
        dmemAck = 1'b0;
        dmemRData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dmemReq) begin
                dmemAck = reqCycle == ackDelay;
                reqCycle++;
            end else begin
                dmemAck = forceAck | ($urandom_range(3) == 0);
                reqCycle = 0;
            end
            dmemRData = dmemAck ? rdWord : $urandom;
        end
    end

    always @(negedge clk) begin
        if (dmemReq) begin
            check("request allowed", 32'(reqAllowed), 1);
            check("dmemAddr", dmemAddr, expAddr);
            check("dmemBe", 32'(dmemBe), 32'(expBe));
            check("dmemWData", dmemWData, expWData);
            check("dmemWe", 32'(dmemWe), 32'(expWe));
        end
        if (wbValid || misalignFault || busTimeout) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected output: wbValid=%b misalign=%b timeout=%b expected none",
                         wbValid, misalignFault, busTimeout);
            end else begin
                got = expQ.pop_front();
                check("event kind", 32'({wbValid, misalignFault, busTimeout}), 32'(got.kind));
                if (got.kind == EV_WB) begin
                    check("wb pc", wbPipeReg.pc, got.wb.pc);
                    check("wb alu_result", wbPipeReg.alu_result, got.wb.alu_result);
                    check("wb r_data", wbPipeReg.r_data, got.wb.r_data);
                    check("wb is_load", 32'(wbPipeReg.is_load), 32'(got.wb.is_load));
                    check("wb rdCtrl", 32'(wbPipeReg.rdCtrl), 32'(got.wb.rdCtrl));
                end
            end
        end
    end

    task automatic issue(input MemoryAccessStagePipeReg p, input int delay, input logic [31:0] rdata);
        automatic Event e;
        automatic int size = p.memWidth == MEM_BYTE ? 1 : p.memWidth == MEM_HALF ? 2 : 4;
        automatic int off = int'(p.aluResult[1:0]);
        automatic logic isMem = p.isLoad | p.isStore;
        automatic logic ok = (p.aluResult % size) == 0;
        automatic logic [31:0] lane;
        automatic int stalls = 0, expStall;
        lane = rdata >> (8 * off);
        if (size == 1) begin
            lane = lane & 32'hFF;
            if (!p.isLoadUnsigned && lane >= 128) lane = lane - 256;
        end else if (size == 2) begin
            lane = lane & 32'hFFFF;
            if (!p.isLoadUnsigned && lane >= 32'h8000) lane = lane - 32'h10000;
        end else begin
            lane = rdata;
        end
        e.wb = '{pc: p.pc, alu_result: p.aluResult, r_data: p.isLoad ? lane : 32'd0,
                 is_load: p.isLoad, rdCtrl: p.rdCtrl};
        e.kind = !isMem ? EV_WB : !ok ? EV_MIS : delay >= T ? EV_TMO : EV_WB;
        expStall = (!isMem || !ok) ? 0 : delay >= T ? T : delay + 1;
        expAddr  = p.aluResult - 32'(off);
        expBe    = size == 1 ? 4'(1 << off) : size == 2 ? 4'(3 << off) : 4'hF;
        expWData = size == 1 ? p.storeData[7:0] * 32'h01010101 :
                   size == 2 ? p.storeData[15:0] * 32'h00010001 : p.storeData;
        expWe    = p.isStore;
        ackDelay = delay;
        rdWord   = rdata;
        expQ.push_back(e);
        memPipeReg = p;
        memValid   = 1'b1;
        reqAllowed = isMem && ok;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!memStall) break;
            stalls++;
        end
        check("memStall cycles", stalls, expStall);
        @(posedge clk);
        #1;
        memValid   = 1'b0;
        reqAllowed = 1'b0;
    endtask

    function automatic MemoryAccessStagePipeReg mk(input int kind, input logic [1:0] width,
                                                    input logic [31:0] addr, input logic [31:0] data,
                                                    input logic uns);
        MemoryAccessStagePipeReg p;
        p.pc = $urandom;
        p.aluResult = addr;
        p.storeData = data;
        p.isLoad = kind == 1;
        p.isStore = kind == 2;
        p.isLoadUnsigned = uns;
        p.memWidth = width;
        p.rdCtrl = RdCtrl'($urandom_range(63));
        return p;
    endfunction

    task automatic checkAllZero(input string tag);
        check({tag, " wbValid"}, 32'(wbValid), 0);
        check({tag, " wbPipeReg"}, 32'(|wbPipeReg), 0);
        check({tag, " dmemReq"}, 32'(dmemReq), 0);
        check({tag, " dmemWe"}, 32'(dmemWe), 0);
        check({tag, " dmemAddr"}, dmemAddr, 0);
        check({tag, " dmemWData"}, dmemWData, 0);
        check({tag, " dmemBe"}, 32'(dmemBe), 0);
        check({tag, " faults"}, 32'({misalignFault, busTimeout}), 0);
        check({tag, " memStall"}, 32'(memStall), 0);
    endtask

    initial begin
        rst = 1'b1;
        memValid = 1'b0;
        memPipeReg = '0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(mk(0, MEM_WORD, 32'h1234, 32'h0, 1'b0), 0, 32'h0);
        issue(mk(1, MEM_BYTE, 32'h103, 32'h0, 1'b0), 2, 32'h80FF_FF00);
        issue(mk(2, MEM_HALF, 32'h202, 32'hABCD_5678, 1'b0), 1, 32'h0);
        issue(mk(1, MEM_WORD, 32'h101, 32'h0, 1'b0), 0, 32'h0);
        issue(mk(1, MEM_WORD, 32'h400, 32'h0, 1'b0), 9, 32'h0);

        // Reset while an access is outstanding, then a stray ack afterwards.
        memPipeReg = mk(1, MEM_WORD, 32'h300, 32'h5555_AAAA, 1'b0);
        expAddr = 32'h300;
        expBe = 4'hF;
        expWData = 32'h5555_AAAA;
        expWe = 1'b0;
        ackDelay = 100;
        memValid = 1'b1;
        reqAllowed = 1'b1;
        repeat (3) @(negedge clk);
        check("request pending", 32'(dmemReq), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        memValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reqAllowed = 1'b0;
        forceAck = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkAllZero("post-reset");
        end
        forceAck = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                memPipeReg = mk(1, 2'($urandom_range(3)), $urandom, $urandom, 1'b0);
                @(posedge clk);
                #1;
            end
            issue(mk($urandom_range(2), 2'($urandom_range(3)), $urandom, $urandom, 1'($urandom_range(1))),
                  $urandom_range(5), $urandom);
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
